// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   CLA_WIDTH / CLA_GROUP : default operand width and lookahead group size
//   pg_t                  : per-bit generate/propagate bundle plus carry-in
//   lookahead_carry()     : one step of the group carry chain, C[j+1] from GG/GP/C[j]
package cla_pkg;

  localparam int CLA_WIDTH = 32;
  localparam int CLA_GROUP = 8;

  typedef struct packed {
    logic [CLA_WIDTH-1:0] g;
    logic [CLA_WIDTH-1:0] p;
    logic                 cin;
  } pg_t;

  // Carry out of a group given its group generate/propagate and carry in.
  function automatic logic lookahead_carry(input logic gg, input logic gp, input logic cin);
    return gg | (gp & cin);
  endfunction

endpackage

// File: rtl/cla_group_gen.sv
// Per-group lookahead generator: reduces GROUP bits of generate/propagate
// to a single group generate (GG) and group propagate (GP).
//   g_i, p_i : per-bit generate/propagate of the group
//   gg_o     : group generates a carry regardless of carry in
//   gp_o     : group propagates its carry in to its carry out
module cla_group_gen #(
  parameter int GROUP = 8
) (
  input  logic [GROUP-1:0] g_i,
  input  logic [GROUP-1:0] p_i,
  output logic             gg_o,
  output logic             gp_o
);

  always_comb begin
    gg_o = 1'b0;
    // GG folds from the LSB upward: a higher bit's generate wins, otherwise
    // the lower generate must be propagated through this bit.
    for (int k = 0; k < GROUP; k++) begin
      gg_o = g_i[k] | (p_i[k] & gg_o);
    end
    gp_o = &p_i;
  end

endmodule

// File: rtl/cla_pg_stage.sv
// First pipeline stage: captures an operand beat as per-bit generate and
// propagate vectors plus carry-in, and owns the input handshake.
//   clk, rst      : clock, synchronous active-high reset (valid flag only)
//   in_valid_i    : operand beat offered
//   a_i, b_i      : operands
//   cin_i         : carry into bit 0
//   next_ready_i  : stage 2 is empty or advancing this cycle
//   in_ready_o    : beat accepted this cycle when in_valid_i is high
//   vld_o         : stage holds a valid beat
//   adv_o         : stage hands its beat to stage 2 this cycle
//   g_o, p_o      : registered generate / propagate
//   cin_o         : registered carry in
module cla_pg_stage
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             next_ready_i,
  output logic             in_ready_o,
  output logic             vld_o,
  output logic             adv_o,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o,
  output logic             cin_o
);

  logic             vld_p1_q, vld_p1_d;
  logic             accept;
  logic [WIDTH-1:0] g_p1_q, p_p1_q;
  logic             cin_p1_q;

  always_comb begin
    adv_o      = vld_p1_q & next_ready_i;
    // Ready ripples back combinationally from the output; no skid buffer.
    in_ready_o = !vld_p1_q | adv_o;
    accept     = in_valid_i & in_ready_o;
    vld_p1_d   = accept | (vld_p1_q & !adv_o);
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= vld_p1_d;
  end

  // ---- stage 1 boundary: operands -> g/p ----
  always_ff @(posedge clk) begin
    if (accept) begin
      g_p1_q   <= a_i & b_i;
      p_p1_q   <= a_i ^ b_i;
      cin_p1_q <= cin_i;
    end
  end

  assign vld_o = vld_p1_q;
  assign g_o   = g_p1_q;
  assign p_o   = p_p1_q;
  assign cin_o = cin_p1_q;

endmodule

// File: rtl/cla_pipelined_adder.sv
// Three-stage pipelined two-level carry-lookahead adder with valid/ready
// handshakes on both sides.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand beat handshake
//   a, b, carry_in       : operands and carry into bit 0
//   out_valid / out_ready: result beat handshake
//   sum                  : (a + b + carry_in) mod 2^WIDTH
//   carry_out            : carry out of bit WIDTH-1
//   overflow             : signed overflow (carry into MSB xor carry out)
// WIDTH must be a multiple of GROUP with at least two groups.
module cla_pipelined_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NGROUPS = WIDTH / GROUP;

  logic               vld_p1, adv_p1, s2_ready;
  logic [WIDTH-1:0]   g_p1, p_p1;
  logic               cin_p1;

  logic [NGROUPS-1:0] gg_p1, gp_p1;
  logic [NGROUPS:0]   grp_c_d;

  logic               vld_p2_q, vld_p2_d, adv_p2;
  logic [WIDTH-1:0]   g_p2_q, p_p2_q;
  logic [NGROUPS:0]   grp_c_p2_q;

  logic [WIDTH-1:0]   bit_c;
  logic [WIDTH-1:0]   sum_d;
  logic               ovf_d;

  logic               vld_p3_q, vld_p3_d, adv_p3;
  logic [WIDTH-1:0]   sum_p3_q;
  logic               cout_p3_q, ovf_p3_q;

  // The top generate bit of every group only feeds the next group's carry,
  // which the group lookahead already supplies.
  logic               unused_grp_top_g;

  // Stall chain: each stage moves when the one after it is empty or moving.
  always_comb begin
    adv_p3   = vld_p3_q & out_ready;
    adv_p2   = vld_p2_q & (!vld_p3_q | adv_p3);
    s2_ready = !vld_p2_q | adv_p2;
    vld_p2_d = adv_p1 | (vld_p2_q & !adv_p2);
    vld_p3_d = adv_p2 | (vld_p3_q & !adv_p3);
  end

  cla_pg_stage #(.WIDTH(WIDTH)) u_pg_stage (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (carry_in),
    .next_ready_i(s2_ready),
    .in_ready_o  (in_ready),
    .vld_o       (vld_p1),
    .adv_o       (adv_p1),
    .g_o         (g_p1),
    .p_o         (p_p1),
    .cin_o       (cin_p1)
  );

  for (genvar j = 0; j < NGROUPS; j++) begin : g_grp
    cla_group_gen #(.GROUP(GROUP)) u_grp_gen (
      .g_i (g_p1[j*GROUP +: GROUP]),
      .p_i (p_p1[j*GROUP +: GROUP]),
      .gg_o(gg_p1[j]),
      .gp_o(gp_p1[j])
    );
  end

  always_comb begin
    grp_c_d    = '0;
    grp_c_d[0] = cin_p1;
    for (int j = 0; j < NGROUPS; j++) begin
      grp_c_d[j+1] = lookahead_carry(gg_p1[j], gp_p1[j], grp_c_d[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
    end
  end

  // ---- stage 2 boundary: g/p -> group carries ----
  always_ff @(posedge clk) begin
    if (adv_p1) begin
      g_p2_q     <= g_p1;
      p_p2_q     <= p_p1;
      grp_c_p2_q <= grp_c_d;
    end
  end

  // Within each group the bit carries ripple from the group's lookahead
  // carry; the ripple never crosses a group boundary.
  always_comb begin
    bit_c = '0;
    for (int j = 0; j < NGROUPS; j++) begin
      bit_c[j*GROUP] = grp_c_p2_q[j];
      for (int k = 0; k < GROUP - 1; k++) begin
        bit_c[j*GROUP + k + 1] = g_p2_q[j*GROUP + k] | (p_p2_q[j*GROUP + k] & bit_c[j*GROUP + k]);
      end
    end
    sum_d = p_p2_q ^ bit_c;
    ovf_d = bit_c[WIDTH-1] ^ grp_c_p2_q[NGROUPS];
  end

  always_comb begin
    unused_grp_top_g = 1'b0;
    for (int j = 0; j < NGROUPS; j++) begin
      unused_grp_top_g = unused_grp_top_g ^ g_p2_q[j*GROUP + GROUP - 1];
    end
  end

  // ---- stage 3 boundary: carries -> sum / carry_out / overflow ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p3_q  <= '0;
      cout_p3_q <= 1'b0;
      ovf_p3_q  <= 1'b0;
    end else if (adv_p2) begin
      sum_p3_q  <= sum_d;
      cout_p3_q <= grp_c_p2_q[NGROUPS];
      ovf_p3_q  <= ovf_d;
    end
  end

  assign out_valid = vld_p3_q;
  assign sum       = sum_p3_q;
  assign carry_out = cout_p3_q;
  assign overflow  = ovf_p3_q;

endmodule

// File: tb/tb_cla_pipelined_adder.sv
module tb_cla_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, carry_in;
  logic        out_valid, out_ready, carry_out, overflow;
  logic [31:0] a, b, sum;

  always #5 clk = ~clk;

  cla_pipelined_adder #(.WIDTH(32), .GROUP(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry_out(carry_out),
    .overflow (overflow)
  );

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        obs_in_ready, obs_out_valid, obs_fire_in;
  logic        hold_pending = 1'b0;
  logic [31:0] held_sum;
  logic        held_co, held_ov;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later,
  // update the reference model for whatever transfers will happen on the
  // next rising edge, then move to the following falling edge.
  task automatic step(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                      input logic ci, input logic ordy, input logic r);
    logic [32:0] full;
    exp_t        e;
    logic        fire_out;
    rst = r; in_valid = v; a = aa; b = bb; carry_in = ci; out_ready = ordy;
    #1;
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    if (hold_pending) begin
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_sum",   {32'd0, sum}, {32'd0, held_sum});
      chk("hold_flags", {62'd0, carry_out, overflow}, {62'd0, held_co, held_ov});
    end
    obs_fire_in = v & in_ready & !r;
    fire_out    = out_valid & ordy & !r;
    if (fire_out) begin
      chk("unexpected_output", {32'd0, q.size()} != 64'd0 ? 64'd1 : 64'd0, 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sum",       {32'd0, sum}, {32'd0, e.s});
        chk("carry_out", {63'd0, carry_out}, {63'd0, e.co});
        chk("overflow",  {63'd0, overflow}, {63'd0, e.ov});
      end
    end
    if (obs_fire_in) begin
      full = {1'b0, aa} + {1'b0, bb} + {32'd0, ci};
      e.s  = full[31:0];
      e.co = full[32];
      e.ov = (aa[31] == bb[31]) && (full[31] != aa[31]);
      q.push_back(e);
    end
    if (r) q.delete();
    hold_pending = out_valid & !ordy & !r;
    held_sum = sum; held_co = carry_out; held_ov = overflow;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_sum"}, {32'd0, sum}, 64'd0);
    chk({tag, "_flags"}, {62'd0, carry_out, overflow}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    hold_pending = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat, bi, acc_at_drop;
    logic        drop_seen;
    logic [31:0] bp_a[4];
    logic [31:0] bp_b[4];

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    check_cleared("reset");

    // Carry through every bit, with latency measurement.
    step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      if (obs_out_valid) begin lat = k; break; end
    end
    chk("latency", 64'(lat), 64'd3);
    idle(2);

    // Signed overflow, then carry-in only.
    step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    idle(4);

    // Cross-group carries.
    step(1'b1, 32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b1, 1'b0);
    idle(4);

    // Back-to-back random beats at full rate.
    for (int i = 0; i < 100; i++) begin
      step(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      chk("b2b_in_ready", {63'd0, obs_in_ready}, 64'd1);
      if (i >= 3) chk("b2b_out_valid", {63'd0, obs_out_valid}, 64'd1);
    end
    idle(4);
    chk("drained_b2b", 64'(q.size()), 64'd0);

    // Backpressure: fill the pipe, hold, then release.
    bp_a = '{32'h10, 32'h20, 32'h30, 32'h40};
    bp_b = '{32'h01, 32'h02, 32'h03, 32'h04};
    bi = 0; drop_seen = 1'b0; acc_at_drop = -1;
    for (int t = 0; t < 14 && bi < 4; t++) begin
      step(1'b1, bp_a[bi], bp_b[bi], 1'b0, (t >= 6), 1'b0);
      if (!obs_in_ready && !drop_seen) begin drop_seen = 1'b1; acc_at_drop = bi; end
      if (t == 5) chk("stall_sum", {32'd0, sum}, 64'h11);
      if (obs_fire_in) bi++;
    end
    chk("bp_accepted_before_drop", 64'(acc_at_drop), 64'd3);
    chk("bp_all_accepted", 64'(bi), 64'd4);
    idle(4);
    chk("drained_bp", 64'(q.size()), 64'd0);

    // Reset with two beats in flight.
    step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    check_cleared("midreset");
    idle(5);

    // Random beats with random backpressure and random gaps.
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'b0);
    end
    idle(6);
    chk("drained_final", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
